// File: rtl/sin_cos_eval_ctrl.sv
// sin_cos_eval_ctrl: folds a 16-bit phase to a quarter-wave and evaluates sin then cos
// from a shared piecewise-linear coefficient ROM with one multiplier, Q1.14 output.
module sin_cos_eval_ctrl #(
    parameter logic ROUND = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [15:0] i_in_phase,
    output logic [6:0]  o_rom_addr,
    input  logic [30:0] i_rom_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_out_sin,
    output logic [15:0] o_out_cos,
    output logic        o_busy
);
    typedef enum logic [2:0] {IDLE, SIN_LK, SIN_MAC, COS_LK, COS_MAC, DONE} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_ph;
    logic [11:0] r_c1;
    logic [18:0] r_c0;
    logic [6:0]  r_rom_addr;
    logic [15:0] r_sin, r_cos;

    logic [15:0] w_cos_ph, w_mac_ph, w_mag, w_res;
    logic [13:0] w_low;
    logic        w_byp;
    logic [25:0] w_prod;
    logic [26:0] w_acc;
    logic [27:0] w_rnd;
    logic [17:0] w_shift;

    // Distance into the quarter-wave; 16384 - x wraps to 0 exactly when x = 0 (the bypass case).
    function automatic logic [13:0] fold_low(input logic [15:0] p);
        return p[14] ? 14'(14'd0 - p[13:0]) : p[13:0];
    endfunction

    function automatic logic [6:0] fold_addr(input logic [15:0] p);
        return 7'(fold_low(p) >> 7);
    endfunction

    assign w_cos_ph = r_ph + 16'h4000;
    assign w_mac_ph = (r_state == COS_MAC) ? w_cos_ph : r_ph;
    assign w_low    = fold_low(w_mac_ph);
    assign w_byp    = w_mac_ph[14] && (w_mac_ph[13:0] == 14'd0);
    assign w_prod   = 26'(r_c1) * 26'(w_low);
    assign w_acc    = 27'(w_prod) + 27'({r_c0, 7'd0});
    assign w_rnd    = 28'(w_acc) + (ROUND ? 28'd512 : 28'd0);
    assign w_shift  = 18'(w_rnd >> 10);
    assign w_mag    = (w_byp || w_shift > 18'd16384) ? 16'd16384 : w_shift[15:0];
    assign w_res    = w_mac_ph[15] ? 16'(-w_mag) : w_mag;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_in_valid ? SIN_LK : IDLE;
            SIN_LK:  w_next = SIN_MAC;
            SIN_MAC: w_next = COS_LK;
            COS_LK:  w_next = COS_MAC;
            COS_MAC: w_next = DONE;
            DONE:    w_next = i_out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ph       <= '0;
            r_c1       <= '0;
            r_c0       <= '0;
            r_rom_addr <= '0;
            r_sin      <= '0;
            r_cos      <= '0;
        end else begin
            if (r_state == IDLE && i_in_valid) begin
                r_ph       <= i_in_phase;
                r_rom_addr <= fold_addr(i_in_phase);
            end
            if (r_state == SIN_LK || r_state == COS_LK) begin
                r_c1 <= i_rom_data[30:19];
                r_c0 <= i_rom_data[18:0];
            end
            if (r_state == SIN_MAC) begin
                r_sin      <= w_res;
                r_rom_addr <= fold_addr(w_cos_ph);
            end
            if (r_state == COS_MAC) r_cos <= w_res;
        end
    end

    assign o_in_ready  = (r_state == IDLE) && !i_reset;
    assign o_busy      = r_state != IDLE;
    assign o_out_valid = r_state == DONE;
    assign o_rom_addr  = r_rom_addr;
    assign o_out_sin   = r_sin;
    assign o_out_cos   = r_cos;
endmodule

// File: doc/sin_cos_eval_ctrl.md
# sin_cos_eval_ctrl

- Sequencer that turns one 16-bit uniform phase into a sin/cos pair for the Box-Muller g2 path.
- It folds the phase into a quarter-wave and drives the shared 128-entry coefficient ROM twice per sample: first for sin, then for cos.
- It evaluates the piecewise-linear segment with a single multiplier and presents the signed Q1.14 pair on a valid/ready output.
- It sits between the u2 uniform source and the sqrt(-2 ln u1) multiplier stage.

## Interface
- ROUND, 1: 1 = round half-up on the final shift; 0 = truncate.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_phase is valid.
- in_ready  out  1  high only in IDLE while reset is low.
- in_phase  in  16  unsigned phase u; angle = 2π·u/65536.
- rom_addr  out  7  registered address to the coefficient ROM.
- rom_data  in  31  ROM word (combinational ROM, same-cycle data):
  - [30:19] = c1, unsigned slope scaled 2^-10.
  - [18:0] = c0, unsigned offset scaled 2^-17.
- out_valid  out  1  out_sin and out_cos are valid.
- out_ready  in  1  downstream accepts the result.
- out_sin  out  16  signed Q1.14 sin(2πu).
- out_cos  out  16  signed Q1.14 cos(2πu).
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SIN_LK, SIN_MAC, COS_LK, COS_MAC, DONE.
  - IDLE: in_valid&in_ready → latch in_phase into ph, go to SIN_LK; rom_addr ← fold(ph).addr.
  - SIN_LK: rom_data is sampled into c1/c0 registers at the exit edge; go to SIN_MAC.
  - SIN_MAC: compute and register the sin result; rom_addr ← fold(ph+0x4000).addr; go to COS_LK.
  - COS_LK → COS_MAC: same as the sin pair, using ph+0x4000 (mod 2^16) and writing out_cos.
  - COS_MAC → DONE: out_valid set.
  - DONE: out_valid&out_ready → out_valid cleared, go to IDLE.
- Fold of a 16-bit phase p: q = p[15:14], x = p[13:0].
  - q0: xf = x, positive. q1: xf = 16384 − x, positive.
  - q2: xf = x, negative. q3: xf = 16384 − x, negative.
  - xf is 15 bits; addr = xf[13:7].
- Magnitude:
  - xf == 16384 (q1/q3 with x = 0): mag = 16384 exactly; ROM data is ignored; addr = 0.
  - Otherwise: acc = c1·xf (26 bits) + (c0 << 7), held in a 27-bit accumulator; mag = (acc + (ROUND ? 512 : 0)) >> 10, saturated to 16384.
- Result = sign ? −mag : mag, in 16-bit two's complement. −0 = 0.
- ph is captured only at accept; later in_phase changes are ignored.
- out_sin/out_cos change only in SIN_MAC/COS_MAC and hold until the next sample's MAC cycles. Both are stable throughout DONE.

## Timing
- Accept in cycle A (IDLE). SIN_LK = A+1, SIN_MAC = A+2, COS_LK = A+3, COS_MAC = A+4, DONE from A+5.
- out_valid is first high in cycle A+5.
- Minimum sample period is 6 cycles: DONE with out_ready high returns to IDLE. There is no IDLE bypass.
- rom_addr holds the sin address during SIN_LK and the cos address during COS_LK. It holds its last value elsewhere.
- Backpressure: DONE persists while out_ready is low. out_valid, out_sin, out_cos stay stable; in_ready stays 0.
- Reset values: state IDLE; in_ready 0 while reset high; out_valid 0; out_sin 0; out_cos 0; rom_addr 0; busy 0; internal registers 0.
- Reset mid-operation, including DONE: the sample is dropped with no output. IDLE is reached on the cycle after reset deasserts.
- in_valid outside IDLE is ignored; there is no queuing.

## Test plan
- Phase 0x0000 → out_sin 0x0000, out_cos 0x4000 (cos via bypass). rom_addr is 0 in both LK cycles.
- Phase 0x4000 → out_sin 0x4000 (bypass), out_cos 0x0000.
- Phase 0x2000, ROM entry 64 = {c1 1130, c0 20338}, ROUND=1:
  - rom_addr = 64 in SIN_LK and COS_LK.
  - out_sin = out_cos = 0x2D3E (11582).
  - out_valid rises exactly 5 cycles after the accept cycle.
- Phase 0xA000 → out_sin = out_cos = 0xD2C2 (−11582).
- Backpressure and throughput:
  - Hold out_ready low for 10 cycles in DONE: outputs stable, in_ready 0.
  - Then out_ready high with in_valid held high and stepping phases: accepts occur every 6 cycles.
- Reset asserted in SIN_MAC: next cycle has out_valid 0, state IDLE, all outputs 0. No result ever appears for that phase.
